climate_controller: RTL



---
 rtl/climate_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/climate_controller.sv
// Hysteresis heater/cooler FSM with minimum-dwell lockout and mode override.
// Define CLIMATE_FAULT_DETECT_EN to add sticky out-of-range sensor fault detection.
module climate_controller #(
    parameter int TEMP_W    = 5,
    parameter int HEAT_ON   = 18,
    parameter int HEAT_OFF  = 20,
    parameter int COOL_ON   = 23,
    parameter int COOL_OFF  = 20,
    parameter int MIN_DWELL = 4
`ifdef CLIMATE_FAULT_DETECT_EN
    ,
    parameter int TEMP_MIN  = 2,
    parameter int TEMP_MAX  = 30,
    parameter int FAULT_CNT = 3
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TEMP_W-1:0] temperature,
    input  logic              temp_valid,
    input  logic [1:0]        mode,
    output logic              heating,
    output logic              cooling,
    output logic [1:0]        state,
    output logic              locked,
    output logic              fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COOLING = 2'b01,
        HEATING = 2'b10,
        FAULT   = 2'b11
    } state_t;

    localparam logic [1:0] MODE_AUTO = 2'b00;
    localparam logic [1:0] MODE_HEAT = 2'b01;
    localparam logic [1:0] MODE_COOL = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    localparam int DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);

    // Thresholds cast to the sample width so every compare is unsigned and wrap-free.
    localparam logic [TEMP_W-1:0] T_HEAT_ON  = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0] T_HEAT_OFF = TEMP_W'(HEAT_OFF);
    localparam logic [TEMP_W-1:0] T_COOL_ON  = TEMP_W'(COOL_ON);
    localparam logic [TEMP_W-1:0] T_COOL_OFF = TEMP_W'(COOL_OFF);

    state_t        cur;
    logic [DW-1:0] dwell;
    logic          can_act;

    assign can_act = temp_valid && (dwell == DWELL_MAX);

`ifdef CLIMATE_FAULT_DETECT_EN
    localparam int FW = (FAULT_CNT > 0) ? $clog2(FAULT_CNT + 1) : 1;
    localparam logic [FW-1:0]     FCNT_MAX = FW'(FAULT_CNT);
    localparam logic [TEMP_W-1:0] T_MIN    = TEMP_W'(TEMP_MIN);
    localparam logic [TEMP_W-1:0] T_MAX    = TEMP_W'(TEMP_MAX);

    logic [FW-1:0] fault_cnt;
    logic          out_of_range;

    assign out_of_range = (temperature < T_MIN) || (temperature > T_MAX);
`endif

    // Priority: reset, fault entry, mode-forced idle, then dwell-gated thresholds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur   <= IDLE;
            dwell <= '0;
`ifdef CLIMATE_FAULT_DETECT_EN
            fault_cnt <= '0;
`endif
        end else begin
            if (dwell != DWELL_MAX) begin
                dwell <= dwell + DW'(1);
            end
`ifdef CLIMATE_FAULT_DETECT_EN
            if (temp_valid) begin
                if (!out_of_range) begin
                    fault_cnt <= '0;
                end else if (fault_cnt != FCNT_MAX) begin
                    fault_cnt <= fault_cnt + FW'(1);
                end
            end
            if (fault_cnt == FCNT_MAX) begin
                if (cur != FAULT) begin
                    cur   <= FAULT;
                    dwell <= '0;
                end
            end else
`endif
            begin
                case (cur)
                    IDLE: begin
                        if (mode != MODE_OFF && can_act) begin
                            if (temperature <= T_HEAT_ON &&
                                (mode == MODE_AUTO || mode == MODE_HEAT)) begin
                                cur   <= HEATING;
                                dwell <= '0;
                            end else if (temperature >= T_COOL_ON &&
                                         (mode == MODE_AUTO || mode == MODE_COOL)) begin
                                cur   <= COOLING;
                                dwell <= '0;
                            end
                        end
                    end
                    HEATING: begin
                        if (mode == MODE_OFF || mode == MODE_COOL ||
                            (can_act && temperature >= T_HEAT_OFF)) begin
                            cur   <= IDLE;
                            dwell <= '0;
                        end
                    end
                    COOLING: begin
                        if (mode == MODE_OFF || mode == MODE_HEAT ||
                            (can_act && temperature <= T_COOL_OFF)) begin
                            cur   <= IDLE;
                            dwell <= '0;
                        end
                    end
                    default: begin
                        cur <= cur;
                    end
                endcase
            end
        end
    end

    assign state   = cur;
    assign heating = (cur == HEATING);
    assign cooling = (cur == COOLING);
    assign locked  = (cur != FAULT) && (dwell < DWELL_MAX);
`ifdef CLIMATE_FAULT_DETECT_EN
    assign fault   = (cur == FAULT);
`else
    assign fault   = 1'b0;
`endif

endmodule
